// File: rtl/mtx_enc_pkg.sv
// Shared constants, encodings and helpers for the matrix instruction encoder.
// Optional feature macro: MTX_ENC_PERF_EN (perf counters on the top level).
package mtx_enc_pkg;

    localparam int ROWS      = 4;
    localparam int MREGS     = 4;
    localparam int ROW_BYTES = 16;
    localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [6:0] MTYPE  = 7'b0001011;
    localparam logic [2:0] M_LD   = 3'b000;
    localparam logic [2:0] M_ST   = 3'b001;
    localparam logic [2:0] M_MOPA = 3'b010;

    typedef enum logic [1:0] {
        MENC_LDT  = 2'b00,
        MENC_STT  = 2'b01,
        MENC_MOPA = 2'b10,
        MENC_RSVD = 2'b11
    } menc_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } menc_state_e;

    function automatic logic [4:0] slice_idx(input logic [1:0] tile,
                                             input logic [RW-1:0] row);
        return 5'(tile) * 5'(ROWS) + 5'(row);
    endfunction

endpackage

// File: rtl/mtx_inst_pack.sv
// Combinational field packer: command fields plus row index -> one Mtype word.
// Slice offsets are built in 12 bits; the encoder already rejected overflow.
module mtx_inst_pack
    import mtx_enc_pkg::*;
(
    input  logic [1:0]    op_i,
    input  logic [1:0]    md_i,
    input  logic [1:0]    ms1_i,
    input  logic [1:0]    ms2_i,
    input  logic [4:0]    rs1_i,
    input  logic [11:0]   imm_i,
    input  logic [RW-1:0] row_i,
    output logic [31:0]   word_o
);

    logic [11:0] off;
    logic [4:0]  slc;

    // Pick the word layout for the current command type.
    always_comb begin
        off    = imm_i + 12'(row_i) * 12'(ROW_BYTES);
        slc    = slice_idx(md_i, row_i);
        word_o = '0;
        unique case (1'b1)
            (op_i == MENC_LDT):
                word_o = {off, rs1_i, M_LD, slc, MTYPE};
            (op_i == MENC_STT):
                word_o = {off[11:5], slc, rs1_i, M_ST, off[4:0], MTYPE};
            (op_i == MENC_MOPA):
                word_o = {7'b0, slice_idx(ms2_i, '0), slice_idx(ms1_i, '0),
                          M_MOPA, slice_idx(md_i, '0), MTYPE};
            default:
                word_o = '0;
        endcase
    end

endmodule

// File: rtl/mtx_inst_encoder.sv
// Expands tile commands (LDT/STT/MOPA) into a stream of Mtype instructions.
// Define MTX_ENC_PERF_EN to add perf_inst_cnt / perf_rej_cnt outputs.
module mtx_inst_encoder
    import mtx_enc_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [1:0]  cmd_md,
    input  logic [1:0]  cmd_ms1,
    input  logic [1:0]  cmd_ms2,
    input  logic [4:0]  cmd_rs1,
    input  logic [11:0] cmd_imm,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_o,
    output logic        busy,
    output logic        err_o
`ifdef MTX_ENC_PERF_EN
    ,
    output logic [31:0] perf_inst_cnt,
    output logic [15:0] perf_rej_cnt
`endif
);

    localparam logic signed [12:0] LAST_SPAN = 13'((ROWS - 1) * ROW_BYTES);
    localparam logic signed [12:0] IMM_MAX   = 13'sd2047;

    menc_state_e   state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [1:0]    op_q, op_d, md_q, md_d;
    logic [1:0]    ms1_q, ms1_d, ms2_q, ms2_d;
    logic [4:0]    rs1_q, rs1_d;
    logic [11:0]   imm_q, imm_d;
    logic          vld_q, vld_d;
    logic [31:0]   inst_q, inst_d;
    logic          err_q, err_d;

    logic          cmd_fire, inst_fire, legal, last_row;
    logic signed [12:0] last_off;
    logic [1:0]    pk_op, pk_md, pk_ms1, pk_ms2;
    logic [4:0]    pk_rs1;
    logic [11:0]   pk_imm;
    logic [RW-1:0] pk_row;
    logic [31:0]   pk_word;

    assign cmd_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign inst_valid = vld_q;
    assign inst_o     = inst_q;
    assign err_o      = err_q;
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign inst_fire  = vld_q && inst_ready;

    // Legality: reserved op, or a load/store whose last slice offset overflows.
    always_comb begin
        last_off = $signed({cmd_imm[11], cmd_imm}) + LAST_SPAN;
        legal    = 1'b1;
        if (cmd_op == MENC_RSVD) begin
            legal = 1'b0;
        end else if (cmd_op != MENC_MOPA && last_off > IMM_MAX) begin
            legal = 1'b0;
        end
    end

    // Packer sees live command fields in IDLE, captured fields while emitting.
    always_comb begin
        pk_op  = cmd_op;
        pk_md  = cmd_md;
        pk_ms1 = cmd_ms1;
        pk_ms2 = cmd_ms2;
        pk_rs1 = cmd_rs1;
        pk_imm = cmd_imm;
        pk_row = '0;
        if (state_q == ST_EMIT) begin
            pk_op  = op_q;
            pk_md  = md_q;
            pk_ms1 = ms1_q;
            pk_ms2 = ms2_q;
            pk_rs1 = rs1_q;
            pk_imm = imm_q;
            pk_row = row_q + RW'(1);
        end
    end

    mtx_inst_pack u_pack (
        .op_i   (pk_op),
        .md_i   (pk_md),
        .ms1_i  (pk_ms1),
        .ms2_i  (pk_ms2),
        .rs1_i  (pk_rs1),
        .imm_i  (pk_imm),
        .row_i  (pk_row),
        .word_o (pk_word)
    );

    assign last_row = (op_q == MENC_MOPA) || (row_q == RW'(ROWS - 1));

    // Next-state: accept/reject in IDLE, step through slices in EMIT.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        op_d    = op_q;
        md_d    = md_q;
        ms1_d   = ms1_q;
        ms2_d   = ms2_q;
        rs1_d   = rs1_q;
        imm_d   = imm_q;
        vld_d   = vld_q;
        inst_d  = inst_q;
        err_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_fire && legal) begin
                    state_d = ST_EMIT;
                    row_d   = '0;
                    op_d    = cmd_op;
                    md_d    = cmd_md;
                    ms1_d   = cmd_ms1;
                    ms2_d   = cmd_ms2;
                    rs1_d   = cmd_rs1;
                    imm_d   = cmd_imm;
                    vld_d   = 1'b1;
                    inst_d  = pk_word;
                end else if (cmd_fire) begin
                    err_d = 1'b1;
                end
            end
            ST_EMIT: begin
                if (inst_fire && last_row) begin
                    state_d = ST_IDLE;
                    row_d   = '0;
                    vld_d   = 1'b0;
                end else if (inst_fire) begin
                    row_d  = row_q + RW'(1);
                    inst_d = pk_word;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            op_q    <= '0;
            md_q    <= '0;
            ms1_q   <= '0;
            ms2_q   <= '0;
            rs1_q   <= '0;
            imm_q   <= '0;
            vld_q   <= 1'b0;
            inst_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            op_q    <= op_d;
            md_q    <= md_d;
            ms1_q   <= ms1_d;
            ms2_q   <= ms2_d;
            rs1_q   <= rs1_d;
            imm_q   <= imm_d;
            vld_q   <= vld_d;
            inst_q  <= inst_d;
            err_q   <= err_d;
        end
    end

`ifdef MTX_ENC_PERF_EN
    logic [31:0] pinst_q;
    logic [15:0] prej_q;

    assign perf_inst_cnt = pinst_q;
    assign perf_rej_cnt  = prej_q;

    // Handshake counter wraps; reject counter saturates.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pinst_q <= '0;
            prej_q  <= '0;
        end else begin
            if (inst_fire) begin
                pinst_q <= pinst_q + 32'd1;
            end
            if (err_d && prej_q != 16'hFFFF) begin
                prej_q <= prej_q + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mtx_inst_encoder.sv
// Scoreboard bench for mtx_inst_encoder: directed cases plus random commands.
// Honours MTX_ENC_PERF_EN to also check the perf counters.
module tb_mtx_inst_encoder;
    import mtx_enc_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0, cmd_md = '0, cmd_ms1 = '0, cmd_ms2 = '0;
    logic [4:0]  cmd_rs1 = '0;
    logic [11:0] cmd_imm = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_o;
    logic        busy, err_o;
`ifdef MTX_ENC_PERF_EN
    logic [31:0] perf_inst_cnt;
    logic [15:0] perf_rej_cnt;
`endif

    mtx_inst_encoder dut (
        .clk        (clk),
        .rstn       (rstn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_md     (cmd_md),
        .cmd_ms1    (cmd_ms1),
        .cmd_ms2    (cmd_ms2),
        .cmd_rs1    (cmd_rs1),
        .cmd_imm    (cmd_imm),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst_o     (inst_o),
        .busy       (busy),
        .err_o      (err_o)
`ifdef MTX_ENC_PERF_EN
        ,
        .perf_inst_cnt (perf_inst_cnt),
        .perf_rej_cnt  (perf_rej_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [31:0] expq[$];
    int hs_cnt = 0;
    int perf_hs = 0;
    int rej_exp = 0;
    int rej_seen = 0;
    int rej_since_rst = 0;
    int rdy_mode = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    // Reference model: push expected words, return 1 if the command is rejected.
    function automatic bit model(input logic [1:0] op, input logic [1:0] md,
                                 input logic [1:0] ms1, input logic [1:0] ms2,
                                 input logic [4:0] rs1, input logic [11:0] imm);
        int simm;
        int off;
        int s;
        int w;
        simm = int'($signed(imm));
        if (op == 2'b11) return 1'b1;
        if (op != 2'b10 && simm + (ROWS - 1) * ROW_BYTES > 2047) return 1'b1;
        if (op == 2'b10) begin
            w = (int'(ms2) * ROWS << 20) | (int'(ms1) * ROWS << 15)
              | (int'(M_MOPA) << 12) | (int'(md) * ROWS << 7) | int'(MTYPE);
            expq.push_back(w);
            return 1'b0;
        end
        for (int r = 0; r < ROWS; r++) begin
            off = (simm + r * ROW_BYTES) & 12'hFFF;
            s = int'(md) * ROWS + r;
            if (op == 2'b00)
                w = (off << 20) | (int'(rs1) << 15) | (int'(M_LD) << 12)
                  | (s << 7) | int'(MTYPE);
            else
                w = ((off >> 5) << 25) | (s << 20) | (int'(rs1) << 15)
                  | (int'(M_ST) << 12) | ((off & 31) << 7) | int'(MTYPE);
            expq.push_back(w);
        end
        return 1'b0;
    endfunction

    // Consumer ready pattern: always, toggling, or random.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) inst_ready = 1'b1;
            else if (rdy_mode == 1) inst_ready = ~inst_ready;
            else inst_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: every presented word must equal the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (err_o) rej_seen++;
                if (inst_valid) begin
                    if (expq.size() == 0) begin
                        fail_now("unexpected_inst");
                    end else begin
                        check("inst_word", inst_o, expq[0]);
                        if (inst_ready) begin
                            void'(expq.pop_front());
                            hs_cnt++;
                            perf_hs++;
                        end
                    end
                end
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [1:0] md,
                        input logic [1:0] ms1, input logic [1:0] ms2,
                        input logic [4:0] rs1, input logic [11:0] imm);
        int n;
        bit rej;
        @(negedge clk);
        cmd_op = op; cmd_md = md; cmd_ms1 = ms1; cmd_ms2 = ms2;
        cmd_rs1 = rs1; cmd_imm = imm; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            fail_now("cmd_ready_timeout");
            cmd_valid = 1'b0;
            return;
        end
        check("drained_at_ready", expq.size(), 0);
        @(posedge clk);
        rej = model(op, md, ms1, ms2, rs1, imm);
        if (rej) begin
            rej_exp++;
            rej_since_rst++;
        end
        #1;
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom); cmd_md = 2'($urandom);
        cmd_ms1 = 2'($urandom); cmd_ms2 = 2'($urandom);
        cmd_rs1 = 5'($urandom); cmd_imm = 12'($urandom);
        @(negedge clk);
        if (rej) begin
            check("rej_err", err_o, 1);
            check("rej_no_inst", inst_valid, 0);
            check("rej_ready", cmd_ready, 1);
        end else begin
            check("lat_valid", inst_valid, 1);
            check("lat_ready_low", cmd_ready, 0);
            check("lat_busy", busy, 1);
            check("lat_no_err", err_o, 0);
        end
    endtask

    task automatic drain(output int n);
        n = 0;
        while (!cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) fail_now("drain_timeout");
        check("drain_empty", expq.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        #2;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_inst_o", inst_o, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err_o, 0);
        @(negedge clk);
        rstn = 1'b1;

        rdy_mode = 0;
        send(2'b00, 2'd1, 2'd0, 2'd0, 5'd5, 12'h010);
        drain(n);
        check("ldt_ready_back", n, ROWS);

        rdy_mode = 1;
        send(2'b01, 2'd2, 2'd0, 2'd0, 5'd3, 12'h000);
        drain(n);

        rdy_mode = 0;
        send(2'b10, 2'd0, 2'd1, 2'd3, 5'd0, 12'h000);
        check("mopa_busy_cycle", busy, 1);
        @(negedge clk);
        check("mopa_busy_drop", busy, 0);

        send(2'b11, 2'd1, 2'd1, 2'd1, 5'd1, 12'h001);
        send(2'b00, 2'd1, 2'd0, 2'd0, 5'd2, 12'h7F0);
        send(2'b01, 2'd3, 2'd0, 2'd0, 5'd7, 12'h7CF);
        drain(n);

        send(2'b00, 2'd3, 2'd0, 2'd0, 5'd9, 12'hF00);
        base = hs_cnt;
        n = 0;
        while (hs_cnt - base < 2 && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (hs_cnt - base < 2) fail_now("reset_wait_timeout");
        rstn = 1'b0;
        #1;
        expq.delete();
        perf_hs = 0;
        rej_since_rst = 0;
        check("midrst_valid", inst_valid, 0);
        check("midrst_inst_o", inst_o, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ready", cmd_ready, 1);
        @(negedge clk);
        rstn = 1'b1;
        send(2'b10, 2'd2, 2'd3, 2'd0, 5'd0, 12'h000);
        drain(n);
        check("mopa_only", n, 1);

        for (int i = 0; i < 60; i++) begin
            logic [11:0] imm;
            rdy_mode = $urandom_range(0, 2);
            if ($urandom_range(0, 2) == 0)
                imm = 12'h7C0 + 12'($urandom_range(0, 63));
            else
                imm = 12'($urandom);
            send(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
                 5'($urandom), imm);
            if ($urandom_range(0, 3) == 0) drain(n);
        end
        rdy_mode = 0;
        drain(n);
        @(negedge clk);
        check("reject_pulses", rej_seen, rej_exp);
`ifdef MTX_ENC_PERF_EN
        check("perf_inst", perf_inst_cnt, perf_hs);
        check("perf_rej", 32'(perf_rej_cnt), rej_since_rst);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
